// File: rtl/axis_output_packer.sv
// Serializes one wide row of signed partial sums into one BUS_WIDTH AXI-Stream word per lane, with TLAST per frame.
// Latency 1 cycle from input accept to lane 0 on m_axis; after that, one word per cycle with no bubble between rows.
// Backpressure: s_axis_tready rises only while the last lane of the held row is being accepted, or when nothing is held.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   frame_rows          input rows per frame, latched when a frame starts (0 = never emit TLAST)
//   s_axis_*            wide input beat: KERNEL_SIZE signed sums, lane 0 at the LSBs
//   m_axis_*            one sum per word; sign-extended, or clamped to [0, 2^DATA_WIDTH-1]
//   frame_done          one-cycle pulse when the TLAST word is accepted
//   busy                a row is held, or a frame has started and is not yet complete
// Optional macro OUT_CLAMP_EN: each lane is clamped to the unsigned pixel range and zero-extended.
module axis_output_packer #(
  parameter  int KERNEL_SIZE    = 3,
  parameter  int DATA_WIDTH     = 8,
  parameter  int WEIGHT_WIDTH   = 8,
  parameter  int BUS_WIDTH      = 32,
  parameter  int LANE_CNT_WIDTH = 2,
  localparam int SUM_WIDTH      = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [15:0]                      frame_rows,
  input  logic [KERNEL_SIZE*SUM_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [BUS_WIDTH-1:0]             m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic                             frame_done,
  output logic                             busy
);

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t                                  state_q;
  logic [KERNEL_SIZE-1:0][SUM_WIDTH-1:0]   row_q;
  logic [LANE_CNT_WIDTH-1:0]               lane_cnt_q;
  logic [15:0]                             row_cnt_q, row_cnt_d;
  logic [15:0]                             frame_len_q, frame_len_d;
  logic                                    last_row_q, last_row_d;
  // Holds s_axis_tready low during reset and releases it one cycle after reset ends.
  logic                                    rdy_en_q;

  logic                 last_lane;
  logic                 s_acc;
  logic                 m_acc;
  logic [SUM_WIDTH-1:0] lane_sel;

  assign last_lane     = (lane_cnt_q == LANE_CNT_WIDTH'(KERNEL_SIZE - 1));
  assign m_axis_tvalid = (state_q == SEND);
  // Combinational from m_axis_tready only, so a new row can replace the old one
  // in the same cycle its last lane leaves.
  assign s_axis_tready = rdy_en_q & ((state_q == EMPTY) | (last_lane & m_axis_tready));
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  assign m_acc         = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid & last_lane & last_row_q;
  assign frame_done    = m_acc & m_axis_tlast;
  assign busy          = (state_q == SEND) | (row_cnt_q != 16'd0);

  assign lane_sel = row_q[lane_cnt_q];

`ifdef OUT_CLAMP_EN
  // Negative sums become 0. Any set bit above the pixel range saturates the lane to all-ones.
  logic [DATA_WIDTH-1:0] lane_clamped;
  always_comb begin
    lane_clamped = lane_sel[DATA_WIDTH-1:0];
    if (lane_sel[SUM_WIDTH-1]) begin
      lane_clamped = '0;
    end else if (lane_sel[SUM_WIDTH-2:DATA_WIDTH] != '0) begin
      lane_clamped = '1;
    end
  end
  assign m_axis_tdata = {{(BUS_WIDTH-DATA_WIDTH){1'b0}}, lane_clamped};
`else
  assign m_axis_tdata = {{(BUS_WIDTH-SUM_WIDTH){lane_sel[SUM_WIDTH-1]}}, lane_sel};
`endif

  // Frame bookkeeping for the row being accepted. A zero length keeps row_cnt at 0,
  // so frame_rows is sampled again on the next row.
  always_comb begin
    frame_len_d = (row_cnt_q == 16'd0) ? frame_rows : frame_len_q;
    last_row_d  = (frame_len_d != 16'd0) && (row_cnt_q == frame_len_d - 16'd1);
    row_cnt_d   = row_cnt_q + 16'd1;
    if (last_row_d || (frame_len_d == 16'd0)) begin
      row_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      row_q       <= '0;
      lane_cnt_q  <= '0;
      row_cnt_q   <= 16'd0;
      frame_len_q <= 16'd0;
      last_row_q  <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (s_acc) begin
        state_q     <= SEND;
        row_q       <= s_axis_tdata;
        lane_cnt_q  <= '0;
        row_cnt_q   <= row_cnt_d;
        frame_len_q <= frame_len_d;
        last_row_q  <= last_row_d;
      end else if (m_acc) begin
        if (last_lane) begin
          state_q <= EMPTY;
        end else begin
          lane_cnt_q <= lane_cnt_q + LANE_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_output_packer.sv
module tb_axis_output_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_rows = 16'd0;
  logic [56:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        frame_done;
  logic        busy;

  axis_output_packer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_rows   (frame_rows),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    int          lane;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   ready_mode = 0;  // 0: always ready, 1: toggle every cycle, 2: never ready

  logic        held = 1'b0;
  logic [31:0] held_dat;
  logic        held_last;

  always @(posedge clk) cyc++;

  // Downstream ready pattern, applied slightly after each edge.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== held_dat || m_axis_tlast !== held_last) begin
          errors++;
          $display("FAIL stall_stable: got vld %0b dat %h last %0b, expected vld 1 dat %h last %0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_dat, held_last);
        end
      end
      held      = m_axis_tvalid && !m_axis_tready;
      held_dat  = m_axis_tdata;
      held_last = m_axis_tlast;
      if (m_axis_tvalid && !m_axis_tready) begin
        checks++;
        if (s_axis_tready) begin
          errors++;
          $display("FAIL in_rdy_stalled: got s_axis_tready 1, expected 0 while output stalled");
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h, expected no word", m_axis_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          acc_cycles.push_back(cyc);
          if (m_axis_tdata !== e.dat || m_axis_tlast !== e.last) begin
            errors++;
            $display("FAIL word lane%0d: got %h last %0b, expected %h last %0b",
                     e.lane, m_axis_tdata, m_axis_tlast, e.dat, e.last);
          end
          checks++;
          if (frame_done !== e.last) begin
            errors++;
            $display("FAIL frame_done: got %0b, expected %0b", frame_done, e.last);
          end
          if (s_axis_tready) begin
            checks++;
            if (e.lane != 2) begin
              errors++;
              $display("FAIL in_rdy_lane: got s_axis_tready 1 on lane %0d, expected only on lane 2", e.lane);
            end
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL frame_done_idle: got 1, expected 0 without accept");
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Caller is aligned one step after a rising edge; returns the same way after the row is accepted.
  task automatic send_row(input logic [18:0] l0, input logic [18:0] l1, input logic [18:0] l2,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                          input bit last, input int npush);
    logic [31:0] ev[3];
    bit acc;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    for (int i = 0; i < npush; i++) exp_q.push_back('{ev[i], (i == 2) ? last : 1'b0, i});
    s_axis_tdata  = {l2, l1, l0};
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL row_accept: got no accept, expected accept within 100 cycles");
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic row_simple(input int base, input bit last);
    send_row(19'(base), 19'(base + 1), 19'(base + 2),
             32'(base), 32'(base + 1), 32'(base + 2), last, 3);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_rdy", 32'(s_axis_tready), 32'd0);
    check("rst_m_vld", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", 32'(s_axis_tready), 32'd1);

    // 1: sign extension and lane order
    fd0 = fd_cnt;
    frame_rows = 16'd1;
`ifdef OUT_CLAMP_EN
    send_row(19'h00005, 19'h7FFFF, 19'h40000, 32'h5, 32'h0, 32'h0, 1'b1, 3);
`else
    send_row(19'h00005, 19'h7FFFF, 19'h40000, 32'h00000005, 32'hFFFFFFFF, 32'hFFFC0000, 1'b1, 3);
`endif
    drain();
    check("t1_frame_done_cnt", 32'(fd_cnt - fd0), 32'd1);

    // 2: back-to-back rows, one word per cycle
    frame_rows = 16'd4;
    acc_cycles.delete();
    row_simple(10, 1'b0);
    row_simple(20, 1'b0);
    row_simple(30, 1'b0);
    row_simple(40, 1'b1);
    drain();
    check("t2_words", 32'(acc_cycles.size()), 32'd12);
    if (acc_cycles.size() == 12) check("t2_span", 32'(acc_cycles[11] - acc_cycles[0]), 32'd11);

    // 3: toggling backpressure
    ready_mode = 1;
    frame_rows = 16'd2;
    row_simple(50, 1'b0);
    row_simple(60, 1'b1);
    drain();
    ready_mode = 0;
    @(posedge clk); #1;

    // 4: frame length latched at frame start
    frame_rows = 16'd2;
    row_simple(70, 1'b0);
    frame_rows = 16'd5;
    row_simple(80, 1'b1);
    for (int r = 0; r < 5; r++) row_simple(90 + 10 * r, r == 4);
    drain();

    // 5: zero length, then reset mid-row
    fd0 = fd_cnt;
    frame_rows = 16'd0;
    for (int r = 0; r < 3; r++) row_simple(150 + 10 * r, 1'b0);
    drain();
    check("t5_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
    frame_rows = 16'd3;
    send_row(19'd200, 19'd201, 19'd202, 32'd200, 32'd201, 32'd202, 1'b0, 1);
    @(posedge clk); #1;  // lane 1 now presented
    ready_mode = 2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_vld", 32'(m_axis_tvalid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_lane0_seen", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    frame_rows = 16'd1;
    row_simple(210, 1'b1);
    drain();

    // 6: clamp vectors
    frame_rows = 16'd1;
`ifdef OUT_CLAMP_EN
    send_row(19'h7FFFF, 19'h00200, 19'h0007F, 32'h0, 32'hFF, 32'h7F, 1'b1, 3);
`else
    send_row(19'h7FFFF, 19'h00200, 19'h0007F, 32'hFFFFFFFF, 32'h00000200, 32'h0000007F, 1'b1, 3);
`endif
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_output_packer.md
Name: axis_output_packer

Overview:
Downstream stage of the convolution top-level. Consumes the wide output-FIFO beat: KERNEL_SIZE signed partial sums, each SUM_WIDTH bits, packed lane 0 at LSBs. Serializes them into one sign-extended BUS_WIDTH word per sum on an AXI-Stream master toward the DMA. Generates TLAST at a run-time programmable frame length (in input rows).

Parameters:
KERNEL_SIZE, 3, number of sum lanes per input beat
DATA_WIDTH, 8, pixel width
WEIGHT_WIDTH, 8, weight width
SUM_WIDTH, DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE (19), width of one lane; localparam, not overridable
BUS_WIDTH, 32, output word width; must be >= SUM_WIDTH
LANE_CNT_WIDTH, 2, width of lane counter; must be >= clog2(KERNEL_SIZE)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
frame_rows  in  16  input rows per frame; sampled at frame start
s_axis_tdata  in  KERNEL_SIZE*SUM_WIDTH  packed signed sums, lane i at bits [i*SUM_WIDTH +: SUM_WIDTH]
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid & tready
m_axis_tdata  out  BUS_WIDTH  one sign-extended sum
m_axis_tvalid  out  1  output word valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last word of frame
frame_done  out  1  one-cycle pulse when the TLAST word is accepted
busy  out  1  high while a row is held or a frame is in progress

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst). In reset all outputs are 0: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0, busy=0. Internal state: lane_cnt=0, row_cnt=0, holding register empty.
- s_axis_tready goes 1 the first cycle after rst deasserts.
- States:
  - EMPTY: holding register empty; s_axis_tready=1; m_axis_tvalid=0.
  - SEND: row held; m_axis_tvalid=1; m_axis_tdata = lane[lane_cnt] sign-extended to BUS_WIDTH.
- EMPTY->SEND on input accept. The row is registered; lane 0 appears on m_axis the next cycle (latency 1).
- In SEND, lane_cnt advances on each m_axis accept. On accept of lane KERNEL_SIZE-1:
  - if s_axis_tvalid is also 1 in that cycle, the new row is loaded, lane_cnt=0, and the state stays SEND. There is no bubble, so throughput is one word per cycle.
  - otherwise the state goes to EMPTY.
- s_axis_tready = EMPTY | (SEND & lane_cnt==KERNEL_SIZE-1 & m_axis_tready). It is combinational from m_axis_tready, with no combinational path from s_axis_tvalid.
- m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0. m_axis_tvalid never drops without an accept.
- Frame counting:
  - At row accept with row_cnt==0, frame_rows is latched into frame_len. frame_rows changes mid-frame are ignored.
  - row_cnt increments on each row accept. It wraps to 0 after the row whose index equals frame_len-1 is accepted.
  - m_axis_tlast=1 only on lane KERNEL_SIZE-1 of that final row.
  - frame_done pulses for 1 cycle in the cycle that word is accepted.
- frame_len==0: TLAST is never asserted and frame_done never pulses. row_cnt stays 0, so frame_rows is re-sampled on every row.
- frame_len==1: every row ends a frame.
- busy = SEND | (row_cnt!=0).
- rst mid-row drops m_axis_tvalid the next cycle. The partially sent row is discarded and no TLAST is emitted.

Optional Feature:
OUT_CLAMP_EN
- Defined: each lane is clamped to the unsigned range [0, 2^DATA_WIDTH-1] before output, then zero-extended to BUS_WIDTH. Negative values give 0; values above 255 give 255. The clamp adds no latency; it is applied combinationally at the holding-register output.
- Undefined: plain sign extension as described in Behaviour.

Test Plan:
1. Sign extension and lane order. Stimulus: frame_rows=1, one beat with lane0=19'h00005, lane1=19'h7FFFF, lane2=19'h40000, m_axis_tready=1. Response: words 32'h00000005, 32'hFFFFFFFF, 32'hFFFC0000 on three consecutive cycles; tlast on the 3rd word only; one frame_done pulse.
2. Back-to-back rows. Stimulus: frame_rows=4, 4 rows held valid continuously, tready=1. Response: 12 words in 12 consecutive cycles; s_axis_tready high on cycles 3, 6, 9; tlast only on word 12.
3. Backpressure. Stimulus: m_axis_tready toggling 1/0 every cycle. Response: data and tlast stable across each stall; no lost or duplicated words; the input stalls until lane 2 is accepted.
4. Frame length sampling. Stimulus: frame_rows=2; change it to 5 after the first row. Response: TLAST still falls on row 2; the next frame uses 5 rows.
5. Zero length and reset. Stimulus: frame_rows=0 for 3 rows. Response: no tlast, no frame_done. Then assert rst during lane 1. Response: m_axis_tvalid=0 on the next cycle; after release, the first row restarts at lane 0 with row_cnt=0.
6. With OUT_CLAMP_EN defined. Stimulus: lanes 19'h7FFFF, 19'h00200, 19'h0007F. Response: words 32'h00000000, 32'h000000FF, 32'h0000007F.
